// File: rtl/int8_mac_instr_pkg.sv
// Shared encodings for the INT8 MAC custom-0 instructions and the dispatch opcode type.
package int8_mac_instr_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

    localparam logic [2:0] F3_MAC8_ACC = 3'b000;
    localparam logic [2:0] F3_MAC8     = 3'b001;
    localparam logic [2:0] F3_MUL8     = 3'b010;
    localparam logic [2:0] F3_CLIP8    = 3'b011;

    typedef enum logic [2:0] {
        MAC8_ACC = 3'd0,
        MAC8     = 3'd1,
        MUL8     = 3'd2,
        CLIP8    = 3'd3,
        ILLEGAL  = 3'd7
    } opcode_t;

    // Anything outside custom-0 with funct7 == 0 and a known funct3 maps to ILLEGAL.
    function automatic opcode_t decode(input logic [31:0] instr);
        opcode_t op;
        op = ILLEGAL;
        if (instr[6:0] == OPCODE_CUSTOM0 && instr[31:25] == 7'd0) begin
            case (instr[14:12])
                F3_MAC8_ACC: op = MAC8_ACC;
                F3_MAC8:     op = MAC8;
                F3_MUL8:     op = MUL8;
                F3_CLIP8:    op = CLIP8;
                default:     op = ILLEGAL;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/int8_mac_result_fifo.sv
// Power-of-two result buffer between the MAC return port and core writeback.
module int8_mac_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    assign head_o = mem[rd_ptr];

endmodule

// File: rtl/int8_mac_issue_unit.sv
// Decodes INT8 MAC instructions, dispatches them to the MAC unit under a credit
// and per-id busy scheme, and buffers returned results for in-order writeback.
module int8_mac_issue_unit
    import int8_mac_instr_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int ID_W     = 3,
    parameter int HARTID_W = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         instr_i,
    input  logic [XLEN-1:0]     rs1_i,
    input  logic [XLEN-1:0]     rs2_i,
    input  logic [XLEN-1:0]     rd_val_i,
    input  logic [HARTID_W-1:0] hartid_i,
    input  logic [ID_W-1:0]     id_i,
    output logic                issue_accept_o,

    output logic [XLEN-1:0]     mac_rs1_o,
    output logic [XLEN-1:0]     mac_rs2_o,
    output logic [XLEN-1:0]     mac_rd_o,
    output opcode_t             mac_opcode_o,
    output logic [HARTID_W-1:0] mac_hartid_o,
    output logic [ID_W-1:0]     mac_id_o,
    output logic [4:0]          mac_rd_addr_o,

    input  logic [XLEN-1:0]     mac_result_i,
    input  logic                mac_valid_i,
    input  logic                mac_we_i,
    input  logic [4:0]          mac_rd_addr_i,
    input  logic [HARTID_W-1:0] mac_hartid_i,
    input  logic [ID_W-1:0]     mac_id_i,

    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic [HARTID_W-1:0] result_hartid_o,
    output logic [ID_W-1:0]     result_id_o,

    output logic                tag_error_o
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int NUM_IDS = 2 ** ID_W;
    localparam int ENTRY_W = XLEN + 1 + 5 + HARTID_W + ID_W;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    opcode_t              opcode;
    logic                 legal;
    logic                 fire;
    logic                 dispatch;
    logic                 push;
    logic                 pop;
    logic                 inflight;
    logic                 post_reset;
    logic [NUM_IDS-1:0]   id_busy;
    logic [NUM_IDS-1:0]   busy_next;
    logic [CNT_W-1:0]     count;
    logic [CNT_W:0]       occupancy;
    logic [ENTRY_W-1:0]   head;

    assign opcode = decode(instr_i);
    assign legal  = (opcode != ILLEGAL);

    // The single inflight slot holds a credit so a returning result always has room.
    assign occupancy      = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign issue_ready_o  = (occupancy < DEPTH_L) && !id_busy[id_i];
    assign issue_accept_o = issue_valid_i && legal;
    assign fire           = issue_valid_i && issue_ready_o;
    assign dispatch       = fire && legal;

    assign push           = mac_valid_i && !post_reset;
    assign result_valid_o = (count != '0);
    assign pop            = result_valid_o && result_ready_i;

    always_comb begin
        mac_rs1_o     = '0;
        mac_rs2_o     = '0;
        mac_rd_o      = '0;
        mac_opcode_o  = ILLEGAL;
        mac_hartid_o  = '0;
        mac_id_o      = '0;
        mac_rd_addr_o = '0;
        if (dispatch) begin
            mac_rs1_o     = rs1_i;
            mac_rs2_o     = rs2_i;
            mac_rd_o      = rd_val_i;
            mac_opcode_o  = opcode;
            mac_hartid_o  = hartid_i;
            mac_id_o      = id_i;
            mac_rd_addr_o = instr_i[11:7];
        end
    end

    // Retire-clear is applied before the dispatch-set so an id can be reused in the same cycle.
    always_comb begin
        busy_next = id_busy;
        if (pop) begin
            busy_next[result_id_o] = 1'b0;
        end
        if (dispatch) begin
            busy_next[id_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inflight    <= 1'b0;
            id_busy     <= '0;
            tag_error_o <= 1'b0;
            post_reset  <= 1'b1;
        end else begin
            post_reset <= 1'b0;
            id_busy    <= busy_next;
            if (dispatch) begin
                inflight <= 1'b1;
            end else if (push) begin
                inflight <= 1'b0;
            end
            if (push && (!id_busy[mac_id_i] || !inflight)) begin
                tag_error_o <= 1'b1;
            end
        end
    end

    int8_mac_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i ({mac_result_i, mac_we_i, mac_rd_addr_i, mac_hartid_i, mac_id_i}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign {result_data_o, result_we_o, result_rd_o, result_hartid_o, result_id_o} = head;

endmodule

// File: tb/tb_int8_mac_issue_unit.sv
// Directed bench for int8_mac_issue_unit with a behavioural 1-cycle INT8 MAC unit model.
module tb_int8_mac_issue_unit;
    import int8_mac_instr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs1_i, rs2_i, rd_val_i;
    logic [1:0]  hartid_i;
    logic [2:0]  id_i;
    logic        issue_accept_o;
    logic [31:0] mac_rs1_o, mac_rs2_o, mac_rd_o;
    opcode_t     mac_opcode_o;
    logic [1:0]  mac_hartid_o;
    logic [2:0]  mac_id_o;
    logic [4:0]  mac_rd_addr_o;
    logic [31:0] mac_result_i = '0;
    logic        mac_valid_i = 1'b0;
    logic        mac_we_i = 1'b0;
    logic [4:0]  mac_rd_addr_i = '0;
    logic [1:0]  mac_hartid_i = '0;
    logic [2:0]  mac_id_i = '0;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic [1:0]  result_hartid_o;
    logic [2:0]  result_id_o;
    logic        tag_error_o;
    logic        spurious;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    int8_mac_issue_unit dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .instr_i(instr_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_val_i(rd_val_i),
        .hartid_i(hartid_i), .id_i(id_i), .issue_accept_o(issue_accept_o),
        .mac_rs1_o(mac_rs1_o), .mac_rs2_o(mac_rs2_o), .mac_rd_o(mac_rd_o),
        .mac_opcode_o(mac_opcode_o), .mac_hartid_o(mac_hartid_o), .mac_id_o(mac_id_o),
        .mac_rd_addr_o(mac_rd_addr_o),
        .mac_result_i(mac_result_i), .mac_valid_i(mac_valid_i), .mac_we_i(mac_we_i),
        .mac_rd_addr_i(mac_rd_addr_i), .mac_hartid_i(mac_hartid_i), .mac_id_i(mac_id_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .result_hartid_o(result_hartid_o), .result_id_o(result_id_o),
        .tag_error_o(tag_error_o)
    );

    function automatic logic [31:0] mac_model(input opcode_t op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] acc);
        logic signed [15:0] p;
        logic [31:0] pext;
        logic [31:0] r;
        p    = $signed(a[7:0]) * $signed(b[7:0]);
        pext = {{16{p[15]}}, p};
        case (op)
            MAC8_ACC: r = acc + pext;
            MAC8:     r = pext;
            MUL8:     r = pext;
            CLIP8: begin
                if ($signed(a) > 32'sd127)       r = 32'd127;
                else if ($signed(a) < -32'sd128) r = 32'hFFFF_FF80;
                else                             r = a;
            end
            default:  r = '0;
        endcase
        return r;
    endfunction

    // MAC unit stand-in: samples the dispatch port at the edge, answers one cycle later.
    always @(posedge clk) begin
        logic        d, sp;
        logic [31:0] res;
        logic [4:0]  addr;
        logic [1:0]  hart;
        logic [2:0]  id;
        d    = (mac_opcode_o != ILLEGAL);
        sp   = spurious;
        res  = mac_model(mac_opcode_o, mac_rs1_o, mac_rs2_o, mac_rd_o);
        addr = mac_rd_addr_o;
        hart = mac_hartid_o;
        id   = mac_id_o;
        #1;
        mac_valid_i   = d || sp;
        mac_we_i      = 1'b1;
        mac_result_i  = d ? res : 32'd99;
        mac_rd_addr_i = d ? addr : 5'd0;
        mac_hartid_i  = d ? hart : 2'd0;
        mac_id_i      = d ? id : 3'd5;
    end

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        return {7'd0, 10'd0, f3, rd, opc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] acc, input logic [2:0] id);
        issue_valid_i = 1'b1;
        instr_i       = ins;
        rs1_i         = a;
        rs2_i         = b;
        rd_val_i      = acc;
        id_i          = id;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0; issue_valid_i = 1'b0; instr_i = '0; rs1_i = '0; rs2_i = '0;
        rd_val_i = '0; hartid_i = '0; id_i = '0; result_ready_i = 1'b1; spurious = 1'b0;

        // Reset state
        tick(); tick(); rst_ni = 1'b1; settle();
        chk("rst_issue_ready", issue_ready_o, 1);
        chk("rst_result_valid", result_valid_o, 0);
        chk("rst_mac_opcode", 32'(mac_opcode_o), 32'(ILLEGAL));
        chk("rst_tag_error", tag_error_o, 0);

        // MAC8_ACC 10 + 5*3, two-cycle issue-to-result
        tick(); drive(mk(OPCODE_CUSTOM0, F3_MAC8_ACC, 5'd7), 32'd5, 32'd3, 32'd10, 3'd1);
        hartid_i = 2'd2; settle();
        chk("acc_accept", issue_accept_o, 1);
        chk("acc_ready", issue_ready_o, 1);
        chk("acc_mac_opcode", 32'(mac_opcode_o), 32'(MAC8_ACC));
        chk("acc_mac_rd", mac_rd_o, 32'd10);
        chk("acc_mac_rd_addr", mac_rd_addr_o, 7);
        chk("acc_mac_id", mac_id_o, 1);
        tick(); issue_valid_i = 1'b0; settle();
        chk("acc_t1_valid", result_valid_o, 0);
        chk("acc_t1_busy_ready", issue_ready_o, 0);
        chk("acc_t1_mac_opcode", 32'(mac_opcode_o), 32'(ILLEGAL));
        tick(); settle();
        chk("acc_t2_valid", result_valid_o, 1);
        chk("acc_t2_data", result_data_o, 32'd25);
        chk("acc_t2_rd", result_rd_o, 7);
        chk("acc_t2_we", result_we_o, 1);
        chk("acc_t2_id", result_id_o, 1);
        chk("acc_t2_hartid", result_hartid_o, 2);
        tick(); settle();
        chk("acc_t3_valid", result_valid_o, 0);

        // Non-custom opcode: handshake completes, nothing dispatched
        tick(); drive(mk(7'b0110011, 3'b000, 5'd7), 32'd1, 32'd1, 32'd0, 3'd0); settle();
        chk("illegal_accept", issue_accept_o, 0);
        chk("illegal_ready", issue_ready_o, 1);
        chk("illegal_mac_opcode", 32'(mac_opcode_o), 32'(ILLEGAL));
        tick(); issue_valid_i = 1'b0; settle();
        chk("illegal_t1_valid", result_valid_o, 0);
        tick(); settle();
        chk("illegal_t2_valid", result_valid_o, 0);

        // Fill with ids 0..3 while writeback is stalled
        result_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); drive(mk(OPCODE_CUSTOM0, F3_MAC8, 5'(k)), 32'(k + 1), 32'd2, 32'd0, 3'(k)); settle();
            chk("fill_ready", issue_ready_o, 1);
        end
        tick(); issue_valid_i = 1'b0; id_i = 3'd4; settle();
        chk("full_credit_ready", issue_ready_o, 0);
        tick(); settle();
        chk("full_ready", issue_ready_o, 0);
        chk("full_head_valid", result_valid_o, 1);
        chk("full_head_data", result_data_o, 32'd2);
        chk("full_head_id", result_id_o, 0);
        tick(); result_ready_i = 1'b1; settle();
        chk("pulse_head_data", result_data_o, 32'd2);
        tick(); result_ready_i = 1'b0; settle();
        chk("pulse_ready_back", issue_ready_o, 1);
        chk("pulse_next_data", result_data_o, 32'd4);
        chk("pulse_next_id", result_id_o, 1);

        // Re-issue of a busy id waits for its retirement
        tick(); drive(mk(OPCODE_CUSTOM0, F3_MAC8, 5'd9), 32'd7, 32'd3, 32'd0, 3'd2); settle();
        chk("busy_ready_0", issue_ready_o, 0);
        tick(); result_ready_i = 1'b1; settle();
        chk("busy_ready_1", issue_ready_o, 0);
        chk("busy_head_id1", result_id_o, 1);
        tick(); settle();
        chk("busy_ready_2", issue_ready_o, 0);
        chk("busy_head_id2", result_id_o, 2);
        chk("busy_head_data2", result_data_o, 32'd6);
        tick(); settle();
        chk("busy_ready_free", issue_ready_o, 1);
        chk("busy_accept", issue_accept_o, 1);
        chk("busy_head_id3", result_id_o, 3);
        tick(); issue_valid_i = 1'b0; settle();
        chk("reissue_t1_valid", result_valid_o, 0);
        tick(); settle();
        chk("reissue_valid", result_valid_o, 1);
        chk("reissue_data", result_data_o, 32'd21);
        chk("reissue_id", result_id_o, 2);
        chk("reissue_rd", result_rd_o, 9);
        tick(); settle();
        chk("reissue_drained", result_valid_o, 0);

        // Back-to-back CLIP8 saturation
        tick(); drive(mk(OPCODE_CUSTOM0, F3_CLIP8, 5'd3), 32'd200, 32'd0, 32'd0, 3'd4); settle();
        chk("clip_a_ready", issue_ready_o, 1);
        chk("clip_a_opcode", 32'(mac_opcode_o), 32'(CLIP8));
        tick(); drive(mk(OPCODE_CUSTOM0, F3_CLIP8, 5'd4), 32'hFFFF_FF38, 32'd0, 32'd0, 3'd5); settle();
        chk("clip_b_ready", issue_ready_o, 1);
        chk("clip_b_no_result", result_valid_o, 0);
        tick(); issue_valid_i = 1'b0; settle();
        chk("clip_a_valid", result_valid_o, 1);
        chk("clip_a_data", result_data_o, 32'd127);
        chk("clip_a_rd", result_rd_o, 3);
        tick(); settle();
        chk("clip_b_valid", result_valid_o, 1);
        chk("clip_b_data", result_data_o, 32'hFFFF_FF80);
        chk("clip_b_rd", result_rd_o, 4);
        tick(); settle();
        chk("clip_drained", result_valid_o, 0);

        // Unsolicited MAC result sets the sticky error and is still buffered
        tick(); spurious = 1'b1; settle();
        chk("tag_before", tag_error_o, 0);
        tick(); spurious = 1'b0; settle();
        chk("tag_not_yet", tag_error_o, 0);
        tick(); settle();
        chk("tag_set", tag_error_o, 1);
        chk("tag_entry_valid", result_valid_o, 1);
        chk("tag_entry_data", result_data_o, 32'd99);
        tick(); settle();
        chk("tag_sticky", tag_error_o, 1);
        chk("tag_entry_popped", result_valid_o, 0);

        // Reset with two entries buffered
        result_ready_i = 1'b0;
        tick(); drive(mk(OPCODE_CUSTOM0, F3_MAC8, 5'd1), 32'd1, 32'd1, 32'd0, 3'd6); settle();
        chk("pre_rst_ready_a", issue_ready_o, 1);
        tick(); drive(mk(OPCODE_CUSTOM0, F3_MAC8, 5'd2), 32'd2, 32'd2, 32'd0, 3'd7); settle();
        chk("pre_rst_ready_b", issue_ready_o, 1);
        tick(); issue_valid_i = 1'b0; settle();
        chk("pre_rst_valid", result_valid_o, 1);
        tick(); rst_ni = 1'b0; settle();
        chk("in_rst_buffered", result_valid_o, 1);
        tick(); rst_ni = 1'b1; id_i = 3'd6; settle();
        chk("post_rst_valid", result_valid_o, 0);
        chk("post_rst_ready", issue_ready_o, 1);
        chk("post_rst_tag", tag_error_o, 0);
        tick(); settle();
        chk("post_rst_valid_2", result_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/int8_mac_issue_unit.md
INT8_MAC_ISSUE_UNIT -- requirements
Module: int8_mac_issue_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 Parameter DEPTH, default 4: result FIFO entries; power of two, at least 2.
REQ-003 Parameter ID_W, default 3: instruction-id width; HARTID_W, default 2: hart-id width.
REQ-004 clk_i  in  1  clock; the only clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset; synchronous, active-low.
REQ-006 issue_valid_i  in  1; issue_ready_o  out  1: core-to-unit instruction handshake.
REQ-007 instr_i  in  32; rs1_i, rs2_i, rd_val_i  in  XLEN each: instruction word, source operands, current rd value (accumulator).
REQ-008 hartid_i  in  HARTID_W; id_i  in  ID_W: tags of the offered instruction.
REQ-009 issue_accept_o  out  1: offered instruction is a legal INT8 MAC instruction; valid while issue_valid_i is high.
REQ-010 mac_rs1_o, mac_rs2_o, mac_rd_o  out  XLEN; mac_opcode_o  out  opcode_t; mac_hartid_o, mac_id_o, mac_rd_addr_o  out  tag widths/5: dispatch port to int8_mac_unit.
REQ-011 mac_result_i  in  XLEN; mac_valid_i, mac_we_i  in  1; mac_rd_addr_i  in  5; mac_hartid_i, mac_id_i  in: return port from int8_mac_unit.
REQ-012 result_valid_o  out  1; result_ready_i  in  1; result_data_o  out  XLEN; result_rd_o  out  5; result_we_o  out  1; result_hartid_o, result_id_o  out: writeback handshake to core.
REQ-013 tag_error_o  out  1: sticky mismatch flag.

Function
REQ-014 Decode: instr_i[6:0]=7'b0001011 and instr_i[31:25]=0; funct3 000 MAC8_ACC, 001 MAC8, 010 MUL8, 011 CLIP8; any other value is not accepted.
REQ-015 Handshake fires when issue_valid_i and issue_ready_o are both high; a non-accepted instruction completes the handshake without dispatch.
REQ-016 issue_ready_o = (fifo_count + inflight < DEPTH) and not id_busy[id_i]; it is combinational from state and id_i.
REQ-017 An accepted handshake drives the mac_* operands, tags and rd_addr (instr_i[11:7]) that cycle; otherwise mac_opcode_o = ILLEGAL and operands are 0.
REQ-018 inflight (1 bit) sets on dispatch and clears on mac_valid_i; int8_mac_unit latency is exactly 1 cycle.
REQ-019 id_busy[ID] sets on dispatch and clears when that entry pops from the FIFO.
REQ-020 On mac_valid_i, the unit pushes {result, we, rd_addr, hartid, id} into the FIFO.
REQ-021 The head entry drives the result_* outputs, with result_valid_o = (count != 0); a pop occurs on result_valid_o and result_ready_i.
REQ-022 A push and a pop in the same cycle leave the count unchanged; pointers wrap modulo DEPTH; a push into a full FIFO cannot occur because of the credit rule.
REQ-023 Issue-to-result minimum latency is 2 cycles (dispatch at T, MAC valid at T+1, result_valid_o at T+2).
REQ-024 Dispatch and clear of the same ID in one cycle: the clear takes effect first, so the new dispatch sets the bit.
REQ-025 If mac_valid_i arrives with mac_id_i not busy, or with no inflight, tag_error_o sets and stays set until reset; the entry is still pushed.

Reset
REQ-026 While rst_ni is low at a clock edge, FIFO pointers, count, inflight, id_busy and tag_error_o clear.
REQ-027 Reset output values: issue_ready_o=1 (all IDs free), result_valid_o=0, mac_opcode_o=ILLEGAL, tag_error_o=0.
REQ-028 Reset mid-operation discards inflight and buffered results; a mac_valid_i in the first cycle after reset is ignored.

Structure
REQ-029 opcode_t, the custom-0 opcode constant and the funct3 encodings live in int8_mac_instr_pkg.
REQ-030 One sub-module: int8_mac_result_fifo, parameterised by width and DEPTH, holding the count and pointers.

Verification
REQ-031 MAC8_ACC, rs1=5, rs2=3, rd=10, rd_addr=7, id=1 -> accept=1; result_data_o=25 and result_rd_o=7 at T+2.
REQ-032 instr_i opcode 7'b0110011 -> accept=0, handshake completes, no mac dispatch, no result.
REQ-033 result_ready_i=0, issue MAC8 ops with ids 0..3 -> the 4th issues, then issue_ready_o=0; the ready_i pulse pops 1 entry and ready returns.
REQ-034 Re-issue id=2 while id 2 is unretired -> issue_ready_o=0 until that entry pops.
REQ-035 Back-to-back CLIP8 200, -200 with ready_i=1 -> results 127, -128 in order, one per cycle.
REQ-036 Reset asserted with 2 entries buffered -> the next cycle gives result_valid_o=0 and issue_ready_o=1.
